// File: rtl/sr_math_unit_param.sv
// sr_math_unit_param
// Iterative unsigned arithmetic coprocessor that sits beside the schoolRISCV
// ALU. The core stalls while busy=1 and writes res to rd when done=1.
//   op 0 = MULU  (shift-add, LSB first, W iterations)
//   op 1 = DIVU  (restoring, MSB first, W iterations; res = {rem, quot})
//   op 2 = reserved (res=0, err=1, one iteration)
//   op 3 = SQRT  (digit-by-digit, W/2 iterations) when SR_MATH_SQRT_EN is
//          defined; otherwise it behaves like op 2 and no sqrt logic exists.
// A divide by zero yields res = {a, all ones}, err=1, in one iteration.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          request, accepted only when busy=0 (IDLE or FIN)
//   op[1:0], a, b  operation and operands, latched on acceptance
//   busy           operation in progress
//   done           one-cycle pulse, res/err valid
//   res[2W-1:0]    result, held until the next operation completes
//   err            error flag, updated together with res
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one iteration per clock edge, iteration down-counter running
// FIN   | done pulse; start here is accepted back-to-back
module sr_math_unit_param #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] res,
  output logic           err
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam int RW    = W + 1;
  localparam int RESW  = 2 * W;
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] N_HALF = CNT_W'(W / 2);
  localparam logic [CNT_W-1:0] N_ONE  = CNT_W'(1);
`ifdef SR_MATH_SQRT_EN
  localparam bit SQRT_EN = 1'b1;
`else
  localparam bit SQRT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       opR;
  logic             errOpR;
  logic [W-1:0]     aR;     // multiplicand / dividend-then-quotient / radicand
  logic [W-1:0]     bR;     // multiplier (shifts right) / divisor
  logic [2*W-1:0]   acc;
  logic [W:0]       rem;

  logic             accept, lastIter, errSel;
  logic [CNT_W-1:0] nSel;

  assign accept   = start && (state != RUN);
  assign lastIter = (state == RUN) && (cnt == N_ONE);

  // Ops that finish in a single iteration with err set.
  assign errSel = (op == 2'd2) || (op == 2'd1 && b == '0) || (op == 2'd3 && !SQRT_EN);
  assign nSel   = errSel ? N_ONE : ((op == 2'd3) ? N_HALF : N_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == N_ONE) stateNext = FIN;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Multiply step: add multiplicand into the upper half, shift right.
  logic [W:0]     mulSum;
  logic [2*W-1:0] mulNext;
  assign mulSum  = {1'b0, acc[2*W-1:W]} + {1'b0, (bR[0] ? aR : {W{1'b0}})};
  assign mulNext = {mulSum, acc[W-1:1]};

  // Divide step: bring in the next dividend bit, trial-subtract the divisor.
  logic [W+1:0] divShift;
  logic         divGe;
  logic [W:0]   remDivNext;
  logic [W-1:0] quotNext;
  assign divShift   = {rem, aR[W-1]};
  assign divGe      = divShift >= {2'b00, bR};
  assign remDivNext = divGe ? RW'(divShift - {2'b00, bR}) : divShift[W:0];
  assign quotNext   = {aR[W-2:0], divGe};

`ifdef SR_MATH_SQRT_EN
  // Sqrt step: bring in two radicand bits, trial-subtract {root, 01}.
  logic [W/2-1:0] rootR, rootNext;
  logic [W:0]     sqShift, sqTrial, sqRemNext;
  logic           sqGe;
  assign sqShift   = {rem[W-2:0], aR[W-1:W-2]};
  assign sqTrial   = RW'({rootR, 2'b01});
  assign sqGe      = sqShift >= sqTrial;
  assign sqRemNext = sqGe ? (sqShift - sqTrial) : sqShift;
  assign rootNext  = {rootR[W/2-2:0], sqGe};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      opR    <= '0;
      errOpR <= 1'b0;
      aR     <= '0;
      bR     <= '0;
      acc    <= '0;
      rem    <= '0;
      res    <= '0;
      err    <= 1'b0;
`ifdef SR_MATH_SQRT_EN
      rootR  <= '0;
`endif
    end else if (accept) begin
      cnt    <= nSel;
      opR    <= op;
      errOpR <= errSel;
      aR     <= a;
      bR     <= b;
      acc    <= '0;
      rem    <= '0;
`ifdef SR_MATH_SQRT_EN
      rootR  <= '0;
`endif
    end else if (state == RUN) begin
      cnt <= cnt - N_ONE;
      if (!errOpR) begin
        if (opR == 2'd0) begin
          acc <= mulNext;
          bR  <= bR >> 1;
        end else if (opR == 2'd1) begin
          rem <= remDivNext;
          aR  <= quotNext;
        end
`ifdef SR_MATH_SQRT_EN
        else if (opR == 2'd3) begin
          rem   <= sqRemNext;
          rootR <= rootNext;
          aR    <= {aR[W-3:0], 2'b00};
        end
`endif
      end
      // Results only become visible on the final edge.
      if (lastIter) begin
        if (errOpR) begin
          err <= 1'b1;
          res <= (opR == 2'd1) ? {aR, {W{1'b1}}} : '0;
        end else begin
          err <= 1'b0;
          if (opR == 2'd0)      res <= mulNext;
          else if (opR == 2'd1) res <= {remDivNext[W-1:0], quotNext};
`ifdef SR_MATH_SQRT_EN
          else                  res <= RESW'(rootNext);
`else
          else                  res <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_math_unit_param.sv
module tb_sr_math_unit_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, err;
  logic [2*W-1:0] res;

  sr_math_unit_param #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2*W-1:0] res;
    logic           err;
    int             n;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks every done against the scoreboard.
  int   busyCnt = 0;
  logic prevDone = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyCnt  = 0;
      prevDone = 1'b0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_done: res=0x%0h err=%0b with empty scoreboard", res, err);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_res"}, 32'(res), 32'(e.res));
          chk({e.name, "_err"}, 32'(err), 32'(e.err));
          chk({e.name, "_busy_cycles"}, 32'(busyCnt), 32'(e.n));
          chk({e.name, "_done_width"}, 32'(prevDone), 32'd0);
        end
        busyCnt = 0;
      end
      prevDone = done;
    end
  end

  task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [2*W-1:0] eRes,
                       input logic eErr, input int eN);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    e.name = name; e.res = eRes; e.err = eErr; e.n = eN;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      nChecks++;
      nFail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #3;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_res",  32'(res),  0);
    chk("reset_err",  32'(err),  0);
    #10 rst_n = 1'b1;

    issue("mulu_200x150", 2'd0, 8'd200, 8'd150, 16'h7530, 1'b0, 8);
    drain();
    issue("divu_200d7",   2'd1, 8'd200, 8'd7,   16'h041C, 1'b0, 8);
    drain();
    issue("divu_55d0",    2'd1, 8'd55,  8'd0,   16'h37FF, 1'b1, 1);
    drain();
    issue("reserved_op",  2'd2, 8'd12,  8'd34,  16'h0000, 1'b1, 1);
    drain();
`ifdef SR_MATH_SQRT_EN
    issue("sqrt_200",     2'd3, 8'd200, 8'd99,  16'h000E, 1'b0, 4);
`else
    issue("sqrt_200",     2'd3, 8'd200, 8'd99,  16'h0000, 1'b1, 1);
`endif
    drain();
    issue("mulu_255x255", 2'd0, 8'd255, 8'd255, 16'hFE01, 1'b0, 8);
    drain();
    issue("mulu_0x77",    2'd0, 8'd0,   8'd77,  16'h0000, 1'b0, 8);
    drain();
    issue("divu_5d9",     2'd1, 8'd5,   8'd9,   16'h0500, 1'b0, 8);
    drain();
    issue("divu_255d1",   2'd1, 8'd255, 8'd1,   16'h00FF, 1'b0, 8);
    drain();

    // Start pulsed mid-run is ignored; start during done is accepted.
    issue("mulu_3x5", 2'd0, 8'd3, 8'd5, 16'h000F, 1'b0, 8);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 8'd9; b = 8'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("b2b_done_seen", 32'(done), 1);
    start = 1'b1; op = 2'd1; a = 8'd9; b = 8'd2;
    e.name = "divu_9d2_b2b"; e.res = 16'h0104; e.err = 1'b0; e.n = 8;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_next", 32'(busy), 1);
    drain();

    // Asynchronous reset in the middle of a multiply: no done afterwards.
    issue("mulu_aborted", 2'd0, 8'd3, 8'd5, 16'h000F, 1'b0, 8);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_res",  32'(res),  0);
    chk("abort_err",  32'(err),  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue("mulu_after_reset", 2'd0, 8'd12, 8'd11, 16'h0084, 1'b0, 8);
    drain();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
